block_code_rx: RTL

//   Receive-side front end for the 8->16 complement block code (codeword = {data, ~data}).

---
 rtl/block_code_rx_if.sv | 21 ++
 rtl/block_code_rx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/block_code_rx_if.sv
// Serial codeword input stream and decoded-byte valid/ready output stream
// of the complement block-code receiver.
interface block_code_rx_if;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       rx_sof;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rx_bit, rx_bit_valid, rx_sof, out_ready,
    input  out_data, out_err, out_valid
  );

  modport slave (
    input  rx_bit, rx_bit_valid, rx_sof, out_ready,
    output out_data, out_err, out_valid
  );
endinterface

// File: rtl/block_code_rx.sv
// Receive front end for the 8->16 complement block code: sof-aligned deserializer,
// complement check, and a small first-word-fall-through result FIFO.
module block_code_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  block_code_rx_if.slave       bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_next;
  logic [14:0] shift_q, shift_next;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic        word_done;
  logic [15:0] word_q;
  logic        word_vld;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic        out_valid_q;
  logic [8:0]  last_q;
  logic [8:0]  head;
  logic        push_err, pop, full, do_push, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // A counter of zero in SHIFT means the previous codeword just completed, so the
  // next valid bit opens a new codeword whether or not it carries sof.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    word_done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_bit_valid && bus.rx_sof) begin
          shift_next   = {14'd0, bus.rx_bit};
          bit_cnt_next = 4'd1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.rx_bit_valid) begin
          if (bus.rx_sof || bit_cnt == 4'd0) begin
            shift_next   = {14'd0, bus.rx_bit};
            bit_cnt_next = 4'd1;
          end else begin
            shift_next   = {shift_q[13:0], bus.rx_bit};
            bit_cnt_next = bit_cnt + 4'd1;
            word_done    = (bit_cnt == 4'd15);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= word_done;
      if (word_done) word_q <= {shift_q, bus.rx_bit};
    end
  end

  assign push_err = (word_q[7:0] != ~word_q[15:8]);
  assign head     = mem[rd_ptr];
  assign pop      = out_valid_q && bus.out_ready;
  assign full     = (count == FULL_CNT);
  assign do_push  = word_vld && (!full || pop);
  assign drop     = word_vld && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_err, word_q[15:8]};
  end

  // out_valid only reflects entries that were already stored before this edge,
  // which gives the extra registered cycle after a push into an empty FIFO and
  // keeps out_ready off the out_valid path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= head;
      end
      case ({do_push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      out_valid_q <= pop ? (count > ONE_CNT) : (count != '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? head[7:0] : last_q[7:0];
  assign bus.out_err   = out_valid_q ? head[8]   : last_q[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (err_clr) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (word_vld && push_err && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
